wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Owns the single register-file write port.
- Shares the port between the in-order pipeline writeback (MEM/WB stage outputs) and a multi-cycle auxiliary unit (long-latency load/divide), whose results queue in a small FIFO.
- Pipeline has priority. A starvation counter forces an aux slot and stalls the pipeline for that cycle.
- Also answers hazard-unit queries on registers with pending aux writes.

Parameters:
- DATA_W, 16, register/data width
- ADDR_W, 4, register address width
- DEPTH, 4, aux pending-write FIFO entries (power of two, >=2)
- STARVE_MAX, 8, consecutive pipeline-won cycles with FIFO non-empty before a forced aux grant

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- wb_valid  in  1  pipeline requests a write (MEM/WB write enable)
- wb_sel  in  1  1 = write wb_mem_data, 0 = write wb_calc_data
- wb_mem_data  in  DATA_W  load result from MEM/WB
- wb_calc_data  in  DATA_W  ALU result from MEM/WB
- wb_addr  in  ADDR_W  destination register from MEM/WB
- stall_o  out  1  pipeline must hold MEM/WB this cycle; its write is not taken
- aux_valid  in  1  aux unit offers a result
- aux_ready  out  1  FIFO can accept; aux_ready = !full
- aux_data  in  DATA_W  aux result
- aux_addr  in  ADDR_W  aux destination register
- q_addr  in  ADDR_W  hazard-unit query register
- q_pending  out  1  any valid FIFO entry targets q_addr (combinational)
- rf_we  out  1  register-file write enable (registered)
- rf_addr  out  ADDR_W  register-file write address (registered)
- rf_wdata  out  DATA_W  register-file write data (registered)

Behaviour:
- Reset (rst_n=0, asynchronous):
  - rf_we=0, rf_addr=0, rf_wdata=0.
  - FIFO empty, rd/wr pointers=0, count=0, starve counter=0.
  - stall_o=0, aux_ready=1, q_pending=0.
- Reset mid-operation discards all queued aux writes. No partial write issues.
- FIFO push: aux_valid && aux_ready at the clock edge. No push while full; aux must hold data until accepted.
- Pointers wrap modulo DEPTH. count is tracked separately (0..DEPTH).
- Grant decision, each cycle, from registered state plus current inputs:
  - force = (starve == STARVE_MAX) && count != 0
  - force: aux head granted (pop); stall_o=1; wb_valid ignored.
  - else wb_valid: pipeline granted; stall_o=0.
  - else count != 0: aux head granted (pop).
  - else: no write.
- stall_o depends only on registered state.
- Starve counter:
  - Increments when the pipeline is granted and count != 0.
  - Clears to 0 on any aux grant or when count == 0.
  - Saturates at STARVE_MAX.
- Registered outputs: the granted write appears on rf_we/rf_addr/rf_wdata at the next rising edge. rf_we=0 when nothing is granted; rf_addr/rf_wdata then hold their previous values.
- Pipeline data mux: wb_sel ? wb_mem_data : wb_calc_data.
- Latency:
  - Pipeline write: 1 cycle.
  - Aux write: pushed at edge t, earliest rf_we at edge t+1 (FIFO non-empty visible after t). No empty-FIFO bypass.
- Simultaneous push and pop: count unchanged, both pointers advance. At full, no push occurs, so a pop frees a slot from the next cycle.
- q_pending: OR over valid entries of (entry_addr == q_addr). The head being popped this cycle still counts. An entry being pushed this cycle does not count.
- Ordering: the arbiter does not reorder or merge. Any WAW/RAW against pending aux writes is prevented upstream by the hazard unit via q_pending.

Optional Feature:
- Macro WB_ARB_STATS_EN.
- Defined: adds outputs stat_pipe_grants, stat_aux_grants, stat_stall_cycles, each 16-bit, saturating at 0xFFFF, reset to 0 by rst_n, incremented on the respective grant or stall_o cycle.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset, then wb_valid=1, wb_sel=0, wb_calc_data=0x1234, wb_addr=3 for one cycle -> next edge rf_we=1, rf_addr=3, rf_wdata=0x1234; following cycle rf_we=0.
- wb_sel=1, wb_mem_data=0xBEEF, wb_calc_data=0x0001, wb_addr=7 -> rf_wdata=0xBEEF, rf_addr=7.
- Push aux (addr 5, 0xAAAA), wb_valid=0 -> q_pending=1 for q_addr=5 the cycle after push; rf_we with 0xAAAA/5 at the following edge; q_pending=0 afterwards.
- Fill FIFO with 4 aux writes while wb_valid=1 continuously -> aux_ready=0 at count 4. After 8 pipeline grants, stall_o=1 for exactly one cycle and aux entry 0 is written. Counter restarts and the pattern repeats every 9 cycles until the FIFO drains.
- Full FIFO, aux_valid held with addr 9 -> not accepted until a pop; accepted the cycle aux_ready returns to 1; written in FIFO order.
- Assert rst_n=0 asynchronously mid-drain with count=3 -> rf_we=0 immediately, aux_ready=1, q_pending=0, no stale writes after release.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority over a queued aux unit,
// with a starvation counter that forces aux slots. Optional grant/stall statistics via WB_ARB_STATS_EN.
module wb_port_arbiter #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 4,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  input  logic              wb_sel,
  input  logic [DATA_W-1:0] wb_mem_data,
  input  logic [DATA_W-1:0] wb_calc_data,
  input  logic [ADDR_W-1:0] wb_addr,
  output logic              stall_o,
  input  logic              aux_valid,
  output logic              aux_ready,
  input  logic [DATA_W-1:0] aux_data,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [ADDR_W-1:0] q_addr,
  output logic              q_pending,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wdata
`ifdef WB_ARB_STATS_EN
  ,
  output logic [15:0]       stat_pipe_grants,
  output logic [15:0]       stat_aux_grants,
  output logic [15:0]       stat_stall_cycles
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ST_W  = $clog2(STARVE_MAX + 1);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ST_W-1:0]   starve_q, starve_d;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  hit;
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

  logic              fifo_full;
  logic              fifo_empty;
  logic              force_aux;
  logic              push;
  logic              pop;
  logic              pipe_grant;
  logic [DATA_W-1:0] pipe_data;

  assign fifo_full  = (count_q == CNT_W'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign force_aux  = (starve_q == ST_W'(STARVE_MAX)) && !fifo_empty;

  // Pipeline loses the port only on a forced slot; an idle pipeline lets the FIFO head drain.
  assign pipe_grant = wb_valid && !force_aux;
  assign pop        = force_aux || (!wb_valid && !fifo_empty);
  assign push       = aux_valid && !fifo_full;
  assign pipe_data  = wb_sel ? wb_mem_data : wb_calc_data;

  assign stall_o    = force_aux;
  assign aux_ready  = !fifo_full;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_hit
      assign hit[gi] = valid_q[gi] && (addr_mem[gi] == q_addr);
    end
  endgenerate

  assign q_pending = |hit;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    if (pop) begin
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
      valid_d[rd_ptr_q] = 1'b0;
    end
    if (push) begin
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
      valid_d[wr_ptr_q] = 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (pop || fifo_empty) begin
      starve_d = '0;
    end else if (pipe_grant && (starve_q != ST_W'(STARVE_MAX))) begin
      starve_d = starve_q + ST_W'(1);
    end
  end

  always_comb begin
    rf_we_d    = pipe_grant || pop;
    rf_addr_d  = rf_addr_q;
    rf_wdata_d = rf_wdata_q;
    if (pipe_grant) begin
      rf_addr_d  = wb_addr;
      rf_wdata_d = pipe_data;
    end else if (pop) begin
      rf_addr_d  = addr_mem[rd_ptr_q];
      rf_wdata_d = data_mem[rd_ptr_q];
    end
  end

  // Entry payload needs no reset: valid_q alone decides what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= aux_addr;
      data_mem[wr_ptr_q] <= aux_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      valid_q    <= '0;
      starve_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_addr_q  <= '0;
      rf_wdata_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      starve_q   <= starve_d;
      rf_we_q    <= rf_we_d;
      rf_addr_q  <= rf_addr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_addr  = rf_addr_q;
  assign rf_wdata = rf_wdata_q;

`ifdef WB_ARB_STATS_EN
  logic [15:0] st_pipe_q, st_pipe_d;
  logic [15:0] st_aux_q, st_aux_d;
  logic [15:0] st_stall_q, st_stall_d;

  always_comb begin
    st_pipe_d  = st_pipe_q;
    st_aux_d   = st_aux_q;
    st_stall_d = st_stall_q;
    if (pipe_grant && (st_pipe_q != 16'hFFFF)) st_pipe_d  = st_pipe_q + 16'd1;
    if (pop && (st_aux_q != 16'hFFFF))         st_aux_d   = st_aux_q + 16'd1;
    if (stall_o && (st_stall_q != 16'hFFFF))   st_stall_d = st_stall_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_pipe_q  <= '0;
      st_aux_q   <= '0;
      st_stall_q <= '0;
    end else begin
      st_pipe_q  <= st_pipe_d;
      st_aux_q   <= st_aux_d;
      st_stall_q <= st_stall_d;
    end
  end

  assign stat_pipe_grants  = st_pipe_q;
  assign stat_aux_grants   = st_aux_q;
  assign stat_stall_cycles = st_stall_q;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus randomized traffic,
// all checked against a queue-based reference model of the arbitration rules.
module tb_wb_port_arbiter;
  localparam int DATA_W     = 16;
  localparam int ADDR_W     = 4;
  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wb_valid;
  logic              wb_sel;
  logic [DATA_W-1:0] wb_mem_data;
  logic [DATA_W-1:0] wb_calc_data;
  logic [ADDR_W-1:0] wb_addr;
  logic              stall_o;
  logic              aux_valid;
  logic              aux_ready;
  logic [DATA_W-1:0] aux_data;
  logic [ADDR_W-1:0] aux_addr;
  logic [ADDR_W-1:0] q_addr;
  logic              q_pending;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_addr;
  logic [DATA_W-1:0] rf_wdata;
`ifdef WB_ARB_STATS_EN
  logic [15:0]       stat_pipe_grants;
  logic [15:0]       stat_aux_grants;
  logic [15:0]       stat_stall_cycles;
`endif

  wb_port_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_sel(wb_sel), .wb_mem_data(wb_mem_data),
    .wb_calc_data(wb_calc_data), .wb_addr(wb_addr), .stall_o(stall_o),
    .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_data(aux_data),
    .aux_addr(aux_addr), .q_addr(q_addr), .q_pending(q_pending),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata)
`ifdef WB_ARB_STATS_EN
    ,
    .stat_pipe_grants(stat_pipe_grants), .stat_aux_grants(stat_aux_grants),
    .stat_stall_cycles(stat_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit verbose  = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: pending aux writes as an ordered queue plus a plain starvation tally.
  logic [ADDR_W-1:0] mq_addr[$];
  logic [DATA_W-1:0] mq_data[$];
  int                starve_m;
  logic              e_we;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_data;
  int                s_pipe, s_aux, s_stall;
  bit                aux_acc;

  task automatic model_reset();
    mq_addr.delete();
    mq_data.delete();
    starve_m = 0;
    e_we     = 1'b0;
    e_addr   = '0;
    e_data   = '0;
    s_pipe   = 0;
    s_aux    = 0;
    s_stall  = 0;
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic cycle();
    int n;
    bit e_stall, e_ready, e_qp, g_pipe, g_aux;
    #1;
    n       = mq_addr.size();
    e_stall = (starve_m == STARVE_MAX) && (n != 0);
    e_ready = (n < DEPTH);
    e_qp    = 1'b0;
    foreach (mq_addr[k]) if (mq_addr[k] == q_addr) e_qp = 1'b1;
    chk("stall_o", stall_o, e_stall);
    chk("aux_ready", aux_ready, e_ready);
    chk("q_pending", q_pending, e_qp);

    g_pipe = !e_stall && wb_valid;
    g_aux  = e_stall || (!wb_valid && n != 0);
    e_we   = g_pipe || g_aux;
    if (g_pipe) begin
      e_addr = wb_addr;
      e_data = wb_sel ? wb_mem_data : wb_calc_data;
      s_pipe++;
    end else if (g_aux) begin
      e_addr = mq_addr.pop_front();
      e_data = mq_data.pop_front();
      s_aux++;
    end
    if (e_stall) s_stall++;
    if (g_aux || n == 0) starve_m = 0;
    else if (g_pipe && starve_m < STARVE_MAX) starve_m++;
    aux_acc = aux_valid && e_ready;
    if (aux_acc) begin
      mq_addr.push_back(aux_addr);
      mq_data.push_back(aux_data);
    end

    @(posedge clk);
    #1;
    chk("rf_we", rf_we, e_we);
    chk("rf_addr", rf_addr, e_addr);
    chk("rf_wdata", rf_wdata, e_data);
`ifdef WB_ARB_STATS_EN
    chk("stat_pipe", stat_pipe_grants, (s_pipe > 16'hFFFF) ? 16'hFFFF : s_pipe);
    chk("stat_aux", stat_aux_grants, (s_aux > 16'hFFFF) ? 16'hFFFF : s_aux);
    chk("stat_stall", stat_stall_cycles, (s_stall > 16'hFFFF) ? 16'hFFFF : s_stall);
`endif
    if (verbose)
      $display("txn t=%0t we=%0b addr=%0d data=0x%04h stall=%0b push=%0b", $time, rf_we, rf_addr, rf_wdata, e_stall, aux_acc);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    wb_valid     = 1'b0;
    wb_sel       = 1'b0;
    wb_mem_data  = '0;
    wb_calc_data = '0;
    wb_addr      = '0;
    aux_valid    = 1'b0;
    aux_data     = '0;
    aux_addr     = '0;
    q_addr       = '0;
  endtask

  task automatic offer_aux(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    aux_valid = 1'b1;
    aux_addr  = a;
    aux_data  = d;
  endtask

  task automatic rand_cycles(input int n, input int wb_pct);
    for (int i = 0; i < n; i++) begin
      wb_valid     = ($urandom_range(0, 99) < wb_pct);
      wb_sel       = 1'($urandom);
      wb_mem_data  = DATA_W'($urandom);
      wb_calc_data = DATA_W'($urandom);
      wb_addr      = ADDR_W'($urandom);
      if (!aux_valid && $urandom_range(0, 99) < 45)
        offer_aux(ADDR_W'($urandom_range(0, 7)), DATA_W'($urandom));
      q_addr = ADDR_W'($urandom_range(0, 7));
      cycle();
      if (aux_acc) aux_valid = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_rf_we", rf_we, 1'b0);
    chk("rst_rf_addr", rf_addr, '0);
    chk("rst_rf_wdata", rf_wdata, '0);
    chk("rst_stall", stall_o, 1'b0);
    chk("rst_aux_ready", aux_ready, 1'b1);
    chk("rst_q_pending", q_pending, 1'b0);
    rst_n = 1'b1;
    cycle();

    // Pipeline write, ALU source
    wb_valid = 1'b1; wb_sel = 1'b0; wb_calc_data = 16'h1234; wb_addr = 4'd3;
    cycle();
    chk("t1_wdata", rf_wdata, 16'h1234);
    chk("t1_addr", rf_addr, 4'd3);
    wb_valid = 1'b0;
    cycle();

    // Pipeline write, load source
    wb_valid = 1'b1; wb_sel = 1'b1; wb_mem_data = 16'hBEEF; wb_calc_data = 16'h0001; wb_addr = 4'd7;
    cycle();
    chk("t2_wdata", rf_wdata, 16'hBEEF);
    chk("t2_addr", rf_addr, 4'd7);
    wb_valid = 1'b0;

    // Single aux write with hazard query
    q_addr = 4'd5;
    offer_aux(4'd5, 16'hAAAA);
    cycle();
    aux_valid = 1'b0;
    cycle();
    chk("t3_wdata", rf_wdata, 16'hAAAA);
    cycle();

    // Fill under continuous pipeline traffic, then hold a 5th offer (addr 9) at full
    wb_valid = 1'b1; wb_sel = 1'b0;
    for (int i = 0; i < 4; i++) begin
      offer_aux(ADDR_W'(i + 1), DATA_W'(16'hC000 + i));
      wb_calc_data = DATA_W'(16'h0100 + i); wb_addr = 4'd15;
      q_addr = ADDR_W'(i + 1);
      cycle();
    end
    chk("fill_ready", aux_ready, 1'b0);
    offer_aux(4'd9, 16'h9999);
    for (int i = 0; i < 40; i++) begin
      wb_calc_data = DATA_W'(16'h0200 + i);
      q_addr = ADDR_W'(i % 10);
      cycle();
      if (aux_acc) aux_valid = 1'b0;
    end
    wb_valid = 1'b0;
    repeat (6) cycle();

    // Asynchronous reset mid-drain with three entries still queued
    wb_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      offer_aux(ADDR_W'(10 + i), DATA_W'(16'hD000 + i));
      cycle();
    end
    aux_valid = 1'b0; wb_valid = 1'b0; q_addr = 4'd11;
    cycle();
    chk("pre_rst_pending", q_pending, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_rf_we", rf_we, 1'b0);
    chk("arst_aux_ready", aux_ready, 1'b1);
    chk("arst_q_pending", q_pending, 1'b0);
    chk("arst_stall", stall_o, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) cycle();

    // Randomized traffic at several pipeline loads
    verbose = 1'b0;
    rand_cycles(600, 95);
    rand_cycles(600, 50);
    rand_cycles(600, 10);
    aux_valid = 1'b0; wb_valid = 1'b0;
    repeat (8) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
